// File: rtl/shk_fifo_slice.sv
`default_nettype none
// ============================================================================
// Module      : shk_fifo_slice
// Description : SHK-bus buffering stage. Request beats pass through a
//               2**AW_FIFO-deep first-word-fall-through FIFO with a registered
//               output stage; the response path is a single register stage.
//               Optional downstream stall watchdog: define SHK_FIFO_TMO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shk_fifo_slice #(
    parameter int WD_SHK_DAT = 32,
    parameter int WD_SHK_ADR = 32,
    parameter int AW_FIFO    = 3,
    parameter int TMO_CYC    = 255
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  s_shk_0_valid,
    input  logic [WD_SHK_ADR-1:0] s_shk_0_maddr,
    input  logic [WD_SHK_DAT-1:0] s_shk_0_mdata,
    input  logic                  s_shk_0_msync,
    output logic                  s_shk_0_ready,
    output logic [WD_SHK_ADR-1:0] s_shk_0_saddr,
    output logic [WD_SHK_DAT-1:0] s_shk_0_sdata,
    output logic                  s_shk_0_ssync,
    output logic                  m_shk_0_valid,
    output logic [WD_SHK_ADR-1:0] m_shk_0_maddr,
    output logic [WD_SHK_DAT-1:0] m_shk_0_mdata,
    output logic                  m_shk_0_msync,
    input  logic                  m_shk_0_ready,
    input  logic [WD_SHK_ADR-1:0] m_shk_0_saddr,
    input  logic [WD_SHK_DAT-1:0] m_shk_0_sdata,
    input  logic                  m_shk_0_ssync,
    output logic [AW_FIFO:0]      o_fifo_cnt,
    output logic                  o_unusual_flg
);

    localparam int c_DEPTH = 1 << AW_FIFO;
    localparam int c_PW    = (AW_FIFO > 0) ? AW_FIFO : 1;
    localparam int c_BW    = WD_SHK_ADR + WD_SHK_DAT + 1;
    localparam int c_CW    = AW_FIFO + 1;

    logic [c_BW-1:0] r_mem [c_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_cnt;
    logic            r_s_ready;
    logic            r_m_valid;
    logic [c_BW-1:0] r_m_beat;
    logic [c_BW-1:0] r_s_resp;

    logic            w_push;
    logic            w_pop;
    logic [c_PW-1:0] w_wr_ptr_nxt;
    logic [c_PW-1:0] w_rd_ptr_nxt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic [c_CW-1:0] w_cnt_rem;
    logic [c_BW-1:0] w_in_beat;
    logic [c_BW-1:0] w_head;

    assign w_push    = s_shk_0_valid & r_s_ready;
    assign w_pop     = r_m_valid & m_shk_0_ready;
    assign w_in_beat = {s_shk_0_maddr, s_shk_0_mdata, s_shk_0_msync};

    assign w_wr_ptr_nxt = !w_push ? r_wr_ptr :
                          (r_wr_ptr == c_PW'(c_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = !w_pop ? r_rd_ptr :
                          (r_rd_ptr == c_PW'(c_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // The head entry stays in memory until popped; the output register mirrors it.
    assign w_cnt_rem = w_pop ? r_cnt - 1'b1 : r_cnt;
    assign w_head    = r_mem[w_rd_ptr_nxt];

    always_ff @(posedge i_sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_beat;
        end
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_beat  <= '0;
            r_s_resp  <= '0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_s_ready <= (w_cnt_nxt != c_CW'(c_DEPTH));
            r_s_resp  <= {m_shk_0_saddr, m_shk_0_sdata, m_shk_0_ssync};
            if (w_pop || !r_m_valid) begin
                if (w_cnt_rem != '0) begin
                    r_m_valid <= 1'b1;
                    r_m_beat  <= w_head;
                end else if (w_push) begin
                    r_m_valid <= 1'b1;
                    r_m_beat  <= w_in_beat;
                end else begin
                    r_m_valid <= 1'b0;
                end
            end
        end
    end

    assign s_shk_0_ready = r_s_ready;
    assign m_shk_0_valid = r_m_valid;
    assign {m_shk_0_maddr, m_shk_0_mdata, m_shk_0_msync} = r_m_beat;
    assign {s_shk_0_saddr, s_shk_0_sdata, s_shk_0_ssync} = r_s_resp;
    assign o_fifo_cnt    = r_cnt;

`ifdef SHK_FIFO_TMO_EN
    localparam logic [15:0] c_TMO = 16'(TMO_CYC);

    logic [15:0] r_tmo_cnt;
    logic        r_unusual_flg;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            r_tmo_cnt     <= '0;
            r_unusual_flg <= 1'b0;
        end else begin
            if (w_pop || !r_m_valid) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != 16'hFFFF) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            // Flag on the edge where the stall count reaches the limit.
            if (r_m_valid && !m_shk_0_ready && (17'(r_tmo_cnt) + 17'd1 >= 17'(c_TMO))) begin
                r_unusual_flg <= 1'b1;
            end
        end
    end

    assign o_unusual_flg = r_unusual_flg;
`else
    logic [15:0] w_unused_tmo;
    assign w_unused_tmo  = 16'(TMO_CYC);
    assign o_unusual_flg = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shk_fifo_slice.sv
`default_nettype none
// ============================================================================
// Module      : tb_shk_fifo_slice
// Description : Scoreboard testbench for shk_fifo_slice (AW_FIFO=3, TMO_CYC=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shk_fifo_slice;

    localparam int WD_SHK_DAT = 32;
    localparam int WD_SHK_ADR = 32;
    localparam int AW_FIFO    = 3;
    localparam int TMO_CYC    = 10;

    logic                  clk;
    logic                  rst_n;
    logic                  s_valid;
    logic [WD_SHK_ADR-1:0] s_maddr;
    logic [WD_SHK_DAT-1:0] s_mdata;
    logic                  s_msync;
    logic                  s_ready;
    logic [WD_SHK_ADR-1:0] s_saddr;
    logic [WD_SHK_DAT-1:0] s_sdata;
    logic                  s_ssync;
    logic                  m_valid;
    logic [WD_SHK_ADR-1:0] m_maddr;
    logic [WD_SHK_DAT-1:0] m_mdata;
    logic                  m_msync;
    logic                  m_ready;
    logic [WD_SHK_ADR-1:0] m_saddr;
    logic [WD_SHK_DAT-1:0] m_sdata;
    logic                  m_ssync;
    logic [AW_FIFO:0]      fifo_cnt;
    logic                  unusual_flg;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    logic [WD_SHK_ADR+WD_SHK_DAT:0] sb_q[$];

    shk_fifo_slice #(
        .WD_SHK_DAT (WD_SHK_DAT),
        .WD_SHK_ADR (WD_SHK_ADR),
        .AW_FIFO    (AW_FIFO),
        .TMO_CYC    (TMO_CYC)
    ) u_dut (
        .i_sys_clk     (clk),
        .i_sys_rst_n   (rst_n),
        .s_shk_0_valid (s_valid),
        .s_shk_0_maddr (s_maddr),
        .s_shk_0_mdata (s_mdata),
        .s_shk_0_msync (s_msync),
        .s_shk_0_ready (s_ready),
        .s_shk_0_saddr (s_saddr),
        .s_shk_0_sdata (s_sdata),
        .s_shk_0_ssync (s_ssync),
        .m_shk_0_valid (m_valid),
        .m_shk_0_maddr (m_maddr),
        .m_shk_0_mdata (m_mdata),
        .m_shk_0_msync (m_msync),
        .m_shk_0_ready (m_ready),
        .m_shk_0_saddr (m_saddr),
        .m_shk_0_sdata (m_sdata),
        .m_shk_0_ssync (m_ssync),
        .o_fifo_cnt    (fifo_cnt),
        .o_unusual_flg (unusual_flg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle, where inputs are stable for the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_valid && s_ready) sb_q.push_back({s_maddr, s_mdata, s_msync});
            if (m_valid && m_ready) begin
                n_pop++;
                if (sb_q.size() == 0) check_val("pop_with_empty_sb", 128'(sb_q.size()), 128'd1);
                else check_val("pop_beat", 128'({m_maddr, m_mdata, m_msync}), 128'(sb_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int exp_pops, input string tag);
        int p0 = n_pop;
        for (int k = 0; k < 40 && fifo_cnt != 0; k++) tick();
        tick();
        check_val({tag, "_cnt"}, 128'(fifo_cnt), 128'd0);
        check_val({tag, "_pops"}, 128'(n_pop - p0), 128'(exp_pops));
        check_val({tag, "_mvalid"}, 128'(m_valid), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst_n = 1'b0; s_valid = 1'b0; s_maddr = '0; s_mdata = '0; s_msync = 1'b0;
        m_ready = 1'b0; m_saddr = '0; m_sdata = '0; m_ssync = 1'b0;

        // Reset state
        #12;
        check_val("rst_sready", 128'(s_ready), 128'd0);
        check_val("rst_mvalid", 128'(m_valid), 128'd0);
        #11 rst_n = 1'b1;
        tick();
        check_val("rel_mvalid", 128'(m_valid), 128'd0);
        check_val("rel_sready", 128'(s_ready), 128'd1);
        check_val("rel_cnt", 128'(fifo_cnt), 128'd0);
        check_val("rel_mbeat", 128'({m_maddr, m_mdata, m_msync}), 128'd0);
        check_val("rel_sresp", 128'({s_saddr, s_sdata, s_ssync}), 128'd0);
        check_val("rel_flg", 128'(unusual_flg), 128'd0);

        // Fill to full with downstream stalled, then drain in order
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1; s_maddr = 32'(i); s_mdata = 32'(i * 16); s_msync = i[0];
            tick();
            if (i == 1) check_val("fill_latency_mvalid", 128'(m_valid), 128'd1);
        end
        check_val("full_cnt", 128'(fifo_cnt), 128'd8);
        check_val("full_sready", 128'(s_ready), 128'd0);
        s_maddr = 32'd9; s_mdata = 32'd144; s_msync = 1'b1;
        repeat (3) tick();
        check_val("full_hold_cnt", 128'(fifo_cnt), 128'd8);
        check_val("full_hold_head", 128'(m_maddr), 128'd1);
        s_valid = 1'b0; m_ready = 1'b1;
        drain(8, "fill_drain");

        // Streaming at one beat per cycle with wrap-around
        p0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1'b1; s_maddr = 32'(100 + i); s_mdata = 32'(i); s_msync = i[0];
            tick();
            check_val("stream_cnt", 128'(fifo_cnt), 128'd1);
            check_val("stream_mvalid", 128'(m_valid), 128'd1);
        end
        s_valid = 1'b0;
        tick();
        check_val("stream_pops", 128'(n_pop - p0), 128'd20);
        check_val("stream_end_cnt", 128'(fifo_cnt), 128'd0);

        // Asynchronous reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_maddr = 32'(200 + i); s_mdata = 32'hDEAD_0000 + 32'(i); s_msync = 1'b1;
            tick();
        end
        s_valid = 1'b0;
        check_val("pre_rst_cnt", 128'(fifo_cnt), 128'd5);
        #3 rst_n = 1'b0;
        #1;
        check_val("async_rst_mvalid", 128'(m_valid), 128'd0);
        check_val("async_rst_cnt", 128'(fifo_cnt), 128'd0);
        check_val("async_rst_sready", 128'(s_ready), 128'd0);
        check_val("async_rst_mbeat", 128'({m_maddr, m_mdata, m_msync}), 128'd0);
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check_val("post_rst_cnt", 128'(fifo_cnt), 128'd0);
        check_val("post_rst_sready", 128'(s_ready), 128'd1);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("post_rst_no_old_beat", 128'(m_valid), 128'd0);
        end

        // Response path register
        m_saddr = 32'hA5; m_sdata = 32'h1234; m_ssync = 1'b1;
        #1;
        check_val("resp_not_yet", 128'({s_saddr, s_sdata, s_ssync}), 128'd0);
        tick();
        check_val("resp_saddr", 128'(s_saddr), 128'hA5);
        check_val("resp_sdata", 128'(s_sdata), 128'h1234);
        check_val("resp_ssync", 128'(s_ssync), 128'd1);
        m_saddr = 32'h5A5A_0001; m_sdata = 32'hCAFE_F00D; m_ssync = 1'b0;
        tick();
        check_val("resp_second", 128'({s_saddr, s_sdata, s_ssync}), 128'({32'h5A5A_0001, 32'hCAFE_F00D, 1'b0}));

        // Downstream stall watchdog
        m_ready = 1'b0;
        s_valid = 1'b1; s_maddr = 32'h300; s_mdata = 32'h3; s_msync = 1'b0;
        tick();
        s_valid = 1'b0;
        repeat (9) tick();
        check_val("tmo_before_limit", 128'(unusual_flg), 128'd0);
        tick();
`ifdef SHK_FIFO_TMO_EN
        check_val("tmo_at_limit", 128'(unusual_flg), 128'd1);
`else
        check_val("tmo_disabled", 128'(unusual_flg), 128'd0);
`endif
        m_ready = 1'b1;
        drain(1, "tmo_drain");
`ifdef SHK_FIFO_TMO_EN
        check_val("tmo_sticky", 128'(unusual_flg), 128'd1);
`else
        check_val("tmo_disabled_after", 128'(unusual_flg), 128'd0);
`endif

        check_val("sb_leftover", 128'(sb_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
